// File: rtl/dot_pkg.sv
// Shared types and default widths for the dot-product pipeline (operand reader and multiplier).
package dot_pkg;

  localparam int DOT_DATA_WIDTH  = 16;
  localparam int DOT_COUNT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } reader_state_t;

endpackage

// File: rtl/dot_operand_reader.sv
// Pops matched A/B word pairs from two 1-cycle-latency FIFOs and strobes them to the multiplier.
// Pop in cycle T -> operand_valid in T+2; stalls in READ while either FIFO is empty.
module dot_operand_reader
  import dot_pkg::*;
#(
  parameter int DATA_WIDTH  = DOT_DATA_WIDTH,
  parameter int COUNT_WIDTH = DOT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] pair_count,
  input  logic                   fifo_a_empty,
  output logic                   fifo_a_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_a_dout,
  input  logic                   fifo_b_empty,
  output logic                   fifo_b_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_b_dout,
  output logic [DATA_WIDTH-1:0]  operand_a,
  output logic [DATA_WIDTH-1:0]  operand_b,
  output logic                   operand_valid,
  output logic                   busy,
  output logic                   read_done
);

  reader_state_t          state_q, state_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                   rd_pending_q;
  logic [DATA_WIDTH-1:0]  operand_a_q, operand_b_q;
  logic                   operand_valid_q;
  logic                   pop;

  // remaining!=0 gating keeps the counter from wrapping at the end of a full-length job.
  assign pop = (state_q == READ) && !fifo_a_empty && !fifo_b_empty
               && (remaining_q != '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (pair_count == '0) begin
            state_d = DONE;
          end else begin
            state_d     = READ;
            remaining_d = pair_count;
          end
        end
      end
      READ: begin
        if (pop) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == COUNT_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!rd_pending_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    fifo_a_rd_en = pop;
    fifo_b_rd_en = pop;
    busy         = (state_q != IDLE);
    read_done    = (state_q == DONE);
  end

  // FIFO dout is valid the cycle after rd_en, so capture one cycle behind the pop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_pending_q    <= 1'b0;
      operand_a_q     <= '0;
      operand_b_q     <= '0;
      operand_valid_q <= 1'b0;
    end else begin
      rd_pending_q    <= pop;
      operand_valid_q <= rd_pending_q;
      if (rd_pending_q) begin
        operand_a_q <= fifo_a_dout;
        operand_b_q <= fifo_b_dout;
      end
    end
  end

  assign operand_a     = operand_a_q;
  assign operand_b     = operand_b_q;
  assign operand_valid = operand_valid_q;

endmodule

// File: tb/tb_dot_operand_reader.sv
// Randomized scoreboard bench for dot_operand_reader with queue-based FIFO models.
module tb_dot_operand_reader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [7:0]  pair_count;
  logic        a_empty, b_empty;
  logic        fifo_a_rd_en, fifo_b_rd_en;
  logic [15:0] a_dout, b_dout;
  logic [15:0] operand_a, operand_b;
  logic        operand_valid, busy, read_done;

  dot_operand_reader dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .pair_count    (pair_count),
    .fifo_a_empty  (a_empty),
    .fifo_a_rd_en  (fifo_a_rd_en),
    .fifo_a_dout   (a_dout),
    .fifo_b_empty  (b_empty),
    .fifo_b_rd_en  (fifo_b_rd_en),
    .fifo_b_dout   (b_dout),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .operand_valid (operand_valid),
    .busy          (busy),
    .read_done     (read_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pops, valids, dones, job_n, start_cyc, last_valid, first_pop, last_pop;
  logic [15:0] fa[$], fb[$], exp_a[$], exp_b[$];
  int pcyc[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, got, got, exp, exp, cyc);
    end
  endtask

  // FIFO models: 1-cycle read latency, empty flag updated at the popping edge.
  always @(posedge clk) begin
    if (fifo_a_rd_en) begin
      pops++;
      pcyc.push_back(cyc);
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (fa.size() > 0) a_dout <= fa.pop_front();
      a_empty <= (fa.size() == 0);
    end
    if (fifo_b_rd_en) begin
      if (fb.size() > 0) b_dout <= fb.pop_front();
      b_empty <= (fb.size() == 0);
    end
  end

  // Monitor: compares every presented pair against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (rstn) begin
      if (fifo_a_rd_en || fifo_b_rd_en) begin
        chk("rd_en_equal", int'(fifo_a_rd_en), int'(fifo_b_rd_en));
        chk("pop_while_empty", int'(a_empty || b_empty), 0);
      end
      if (operand_valid) begin
        valids++;
        last_valid = cyc;
        if (exp_a.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          chk("operand_a", int'(operand_a), int'(exp_a.pop_front()));
          chk("operand_b", int'(operand_b), int'(exp_b.pop_front()));
        end
        if (pcyc.size() > 0) chk("valid_latency", cyc - pcyc.pop_front(), 2);
      end
      if (read_done) begin
        dones++;
        chk("done_vs_valid", int'(operand_valid), 0);
        chk("done_timing", cyc, (job_n == 0) ? start_cyc + 1 : last_valid + 1);
      end
      if (start && !busy) start_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic job(input int n, input int extra_a, input int b_delay,
                     input bit directed, input bit interfere);
    logic [15:0] dA[3];
    logic [15:0] dB[3];
    logic [15:0] w;
    logic [15:0] bw[$];
    int lim;
    bit sent;
    dA = '{16'h0102, 16'h0304, 16'h0506};
    dB = '{16'h0A0B, 16'h0C0D, 16'h0E0F};
    fa.delete(); fb.delete(); exp_a.delete(); exp_b.delete(); pcyc.delete();
    pops = 0; valids = 0; dones = 0; job_n = n; first_pop = -1; last_pop = -1;
    for (int i = 0; i < n + extra_a; i++) begin
      w = directed ? dA[i] : 16'($urandom);
      fa.push_back(w);
      if (i < n) exp_a.push_back(w);
    end
    for (int i = 0; i < n; i++) begin
      w = directed ? dB[i] : 16'($urandom);
      bw.push_back(w);
      exp_b.push_back(w);
    end
    a_empty = (fa.size() == 0);
    if (b_delay == 0) begin
      foreach (bw[i]) fb.push_back(bw[i]);
      b_empty = (fb.size() == 0);
    end
    start = 1'b1;
    pair_count = 8'(n);
    step();
    start = 1'b0;
    if (b_delay > 0) begin
      repeat (b_delay) step();
      chk("stall_pops", pops, 0);
      foreach (bw[i]) fb.push_back(bw[i]);
      b_empty = (fb.size() == 0);
    end
    lim = 0;
    sent = 1'b0;
    while (dones == 0 && lim < n + 40) begin
      if (interfere && !sent && pops >= 1) begin
        start = 1'b1;
        pair_count = 8'd9;
        sent = 1'b1;
      end else if (interfere && read_done) begin
        start = 1'b1;
        pair_count = 8'd9;
      end
      step();
      start = 1'b0;
      lim++;
    end
    chk("done_seen", dones, 1);
    repeat (6) step();
    chk("pops", pops, n);
    chk("valids", valids, n);
    chk("done_count", dones, 1);
    chk("fifo_a_left", fa.size(), extra_a);
    chk("fifo_b_left", fb.size(), 0);
    chk("busy_after", int'(busy), 0);
    chk("scoreboard_drained", exp_a.size(), 0);
    if (b_delay == 0 && n > 0) chk("back_to_back", last_pop - first_pop, n - 1);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; pair_count = '0;
    a_empty = 1'b1; b_empty = 1'b1; a_dout = '0; b_dout = '0;
    pops = 0; valids = 0; dones = 0; job_n = 0;
    start_cyc = 0; last_valid = 0; first_pop = -1; last_pop = -1;
    repeat (3) step();
    chk("rst_operand_a", int'(operand_a), 0);
    chk("rst_operand_b", int'(operand_b), 0);
    chk("rst_valid", int'(operand_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_read_done", int'(read_done), 0);
    chk("rst_rd_en", int'(fifo_a_rd_en | fifo_b_rd_en), 0);
    rstn = 1'b1;
    step();

    job(3, 0, 0, 1'b1, 1'b0);
    job(0, 0, 0, 1'b0, 1'b0);
    job(4, 3, 5, 1'b0, 1'b0);
    job(2, 0, 0, 1'b0, 1'b1);
    job($urandom_range(1, 20), $urandom_range(0, 4), $urandom_range(0, 6), 1'b0, 1'b0);

    // Reset lands on the edge of the 2nd pop: that pop happens, nothing is captured after it.
    begin
      int lim;
      fa.delete(); fb.delete(); exp_a.delete(); exp_b.delete(); pcyc.delete();
      pops = 0; valids = 0; dones = 0; job_n = 5;
      for (int i = 0; i < 5; i++) begin
        fa.push_back(16'($urandom));
        fb.push_back(16'($urandom));
      end
      a_empty = 1'b0; b_empty = 1'b0;
      start = 1'b1; pair_count = 8'd5;
      step();
      start = 1'b0;
      lim = 0;
      while (pops < 1 && lim < 20) begin
        step();
        lim++;
      end
      chk("rst_job_first_pop", pops, 1);
      rstn = 1'b0;
      step();
      exp_a.delete(); exp_b.delete(); pcyc.delete();
      valids = 0;
      chk("rst_mid_pops", pops, 2);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_valid", int'(operand_valid), 0);
      chk("rst_mid_operand_a", int'(operand_a), 0);
      chk("rst_mid_operand_b", int'(operand_b), 0);
      rstn = 1'b1;
      repeat (10) step();
      chk("rst_no_more_pops", pops, 2);
      chk("rst_no_valids", valids, 0);
      chk("rst_no_done", dones, 0);
      chk("rst_idle", int'(busy), 0);
      chk("rst_rd_en_low", int'(fifo_a_rd_en | fifo_b_rd_en), 0);
    end

    job(255, 0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
